instr_sequencer: RTL and testbench

- Control and sequencing stage directly upstream of reg_file.
- Accepts one 32-bit instruction word at a time over a valid/ready handshake and decodes its opcode and register fields.
- Drives reg_file addr1/addr2/addr3/valid_opcode, presents the opcode to the ALU, waits the ALU latency, then returns the ALU result on reg_file `in` for write-back to addr3.
- Serial: one instruction in flight, no pipelining.

---
 rtl/instr_sequencer.sv | 133 +++++++++++++
 tb/tb_instr_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Serial instruction sequencer feeding reg_file and the ALU.
// One instruction in flight: accept, decode, read, wait ALU latency, write back.
module instr_sequencer #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       addr1,
    output logic [4:0]       addr2,
    output logic [4:0]       addr3,
    output logic             valid_opcode,
    output logic [5:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    output logic [31:0]      rf_in,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t            r_state;
    logic [OP_W-1:0]   r_op;
    logic [WAIT_W-1:0] r_wait;

    logic [OP_W-1:0]   w_op;
    logic [4:0]        w_src1;
    logic [4:0]        w_src2;
    logic [4:0]        w_dst;
    logic              w_unused_bits;

    assign w_op          = instr[31:26];
    assign w_src1        = instr[25:21];
    assign w_src2        = instr[20:16];
    assign w_dst         = instr[15:11];
    assign w_unused_bits = &{1'b0, instr[10:0]};

    function automatic logic f_legal(input logic [OP_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8,
            6'd11, 6'd13, 6'd15: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Outputs are loaded one edge ahead so each is valid during the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_wait       <= '0;
            instr_ready  <= 1'b1;
            addr1        <= '0;
            addr2        <= '0;
            addr3        <= '0;
            alu_opcode   <= '0;
            rf_in        <= '0;
            retired      <= '0;
            valid_opcode <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            valid_opcode <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op        <= w_op;
                        instr_ready <= 1'b0;
                        r_state     <= S_DECODE;
                        if (f_legal(w_op)) begin
                            addr1      <= w_src1;
                            addr2      <= w_src2;
                            addr3      <= w_dst;
                            alu_opcode <= w_op;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    if (f_legal(r_op)) begin
                        r_state <= S_READ;
                    end else begin
                        instr_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_wait  <= WAIT_W'(ALU_LAT);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_wait <= WAIT_W'(1)) begin
                        rf_in        <= alu_result;
                        valid_opcode <= 1'b1;
                        done         <= 1'b1;
                        r_state      <= S_WRITE;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_WRITE: begin
                    retired     <= retired + CNT_W'(1);
                    instr_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a behavioural reg_file/ALU environment.
module tb_instr_sequencer;

    localparam int unsigned L  = 3;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [4:0]    addr1, addr2, addr3;
    logic          valid_opcode;
    logic [5:0]    alu_opcode;
    logic [31:0]   alu_result;
    logic [31:0]   rf_in;
    logic          done;
    logic          illegal;
    logic [CW-1:0] retired;

    instr_sequencer #(.ALU_LAT(L), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .valid_opcode(valid_opcode), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .rf_in(rf_in), .done(done), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] seed(input int i);
        if (i < 8) return 32'(i + 1);
        return 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (op)
            6'd1:    return a + b;
            6'd2:    return a ^ b;
            6'd3:    return a | b;
            6'd4:    return (a < b) ? a : b;
            6'd5:    return a & b;
            6'd6:    return a - b;
            6'd7:    return (a > b) ? a : b;
            6'd8:    return 32'd0 - a;
            6'd11: begin
                s = {1'b0, a} + {1'b0, b};
                return s[32:1];
            end
            6'd13:   return a[31] ? 32'd0 - a : a;
            6'd15:   return ~a;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Environment: registered-read register file and an ALU with L cycles of latency.
    logic [31:0] rf [32];
    logic [31:0] out1, out2;
    logic        rf_loaded = 1'b0;
    logic [31:0] pipe [15];

    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf[i] <= seed(i);
            rf_loaded <= 1'b1;
        end else if (valid_opcode) begin
            rf[addr3] <= rf_in;
        end
        out1 <= rf[addr1];
        out2 <= rf[addr2];
        pipe[0] <= alu_f(alu_opcode, out1, out2);
        for (int i = 1; i < 15; i++) pipe[i] <= pipe[i-1];
    end

    if (L == 1) begin : g_comb
        assign alu_result = alu_f(alu_opcode, out1, out2);
    end else begin : g_pipe
        assign alu_result = pipe[L-2];
    end

    // Reference model state and scoreboard.
    typedef struct {
        bit          ill;
        logic [5:0]  op;
        logic [4:0]  s1, s2, d;
        logic [31:0] val;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [32];
    logic [5:0]  legal_ops [11] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd11, 6'd13, 6'd15};
    int          exp_ret = 0;
    bit          pending_ret = 1'b0;
    bit          held_prev = 1'b0;
    bit          prev_ill = 1'b0;
    int          prev_acc = 0;
    logic [4:0]  last_a1 = '0, last_a2 = '0, last_a3 = '0;
    logic [5:0]  last_op = '0;

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] d, input logic [10:0] junk);
        return {op, s1, s2, d, junk};
    endfunction

    task automatic reset_bookkeeping();
        q.delete();
        exp_ret     = 0;
        pending_ret = 1'b0;
        held_prev   = 1'b0;
        last_a1 = '0; last_a2 = '0; last_a3 = '0; last_op = '0;
    endtask

    // Monitor: pops an expectation whenever the DUT shows a write or an illegal pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid_opcode || illegal || done) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {29'd0, valid_opcode, illegal, done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    if (e.ill) begin
                        chk("illegal_pulse", 32'(illegal), 32'd1);
                        chk("illegal_no_write", 32'(valid_opcode), 32'd0);
                        chk("illegal_time", 32'(cyc), 32'(e.acc));
                    end else begin
                        chk("write_en", 32'(valid_opcode), 32'd1);
                        chk("write_done", 32'(done), 32'd1);
                        chk("write_time", 32'(cyc), 32'(e.acc + 2 + int'(L)));
                        chk("write_addr3", 32'(addr3), 32'(e.d));
                        chk("write_data", rf_in, e.val);
                        chk("write_addr12", {22'd0, addr1, addr2}, {22'd0, e.s1, e.s2});
                        chk("write_opcode", 32'(alu_opcode), 32'(e.op));
                        exp_ret = (exp_ret + 1) % (1 << CW);
                    end
                    pending_ret = 1'b1;
                end
            end else if (pending_ret) begin
                chk("retired", 32'(retired), 32'(exp_ret));
                pending_ret = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) begin
            instr = $urandom;
            @(negedge clk);
        end
    endtask

    // Present one word (called at a negedge); returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] w, input bit keep);
        exp_t e;
        int   n;
        instr_valid = 1'b1;
        instr       = w;
        n = 0;
        while (!instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        e.op  = w[31:26];
        e.s1  = w[25:21];
        e.s2  = w[20:16];
        e.d   = w[15:11];
        e.ill = !is_legal(e.op);
        e.acc = cyc + 1;
        e.val = '0;
        if (!e.ill) begin
            e.val = alu_f(e.op, mdl[e.s1], mdl[e.s2]);
            mdl[e.d] = e.val;
        end
        q.push_back(e);
        if (held_prev)
            chk("accept_gap", 32'(e.acc - prev_acc), prev_ill ? 32'd2 : 32'(4 + int'(L)));
        prev_acc = e.acc;
        prev_ill = e.ill;
        @(negedge clk);
        if (!keep) instr_valid = 1'b0;
        chk("busy_ready", 32'(instr_ready), 32'd0);
        if (!e.ill) begin
            last_a1 = e.s1; last_a2 = e.s2; last_a3 = e.d; last_op = e.op;
        end
        chk("decode_addr1", 32'(addr1), 32'(last_a1));
        chk("decode_addr2", 32'(addr2), 32'(last_a2));
        chk("decode_addr3", 32'(addr3), 32'(last_a3));
        chk("decode_opcode", 32'(alu_opcode), 32'(last_op));
        if (e.ill) begin
            @(negedge clk);
            chk("illegal_ready_back", 32'(instr_ready), 32'd1);
        end
        held_prev = keep;
    endtask

    task automatic drain();
        int n;
        n = 0;
        instr_valid = 1'b0;
        while ((q.size() != 0 || pending_ret) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        held_prev = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, "_valid_opcode"}, 32'(valid_opcode), 32'd0);
        chk({tag, "_retired"}, 32'(retired), 32'd0);
        chk({tag, "_addrs"}, {17'd0, addr1, addr2, addr3}, 32'd0);
        chk({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
        chk({tag, "_rf_in"}, rf_in, 32'd0);
        chk({tag, "_pulses"}, {30'd0, done, illegal}, 32'd0);
    endtask

    initial begin
        logic [5:0] op;
        bit         keep;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        for (int i = 0; i < 32; i++) mdl[i] = seed(i);
        reset_bookkeeping();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        issue(mk(6'd1, 5'd2, 5'd3, 5'd4, 11'h5A5), 1'b0);
        issue(mk(6'd9, 5'd1, 5'd1, 5'd1, 11'h000), 1'b0);
        idle(2);
        issue(mk(6'd6, 5'd5, 5'd6, 5'd7, 11'h7FF), 1'b1);
        issue(mk(6'd8, 5'd7, 5'd0, 5'd9, 11'h123), 1'b0);
        drain();

        // Reset asserted during EXEC drops the write.
        instr_valid = 1'b1;
        instr       = mk(6'd1, 5'd8, 5'd9, 5'd10, 11'h0);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_exec_reset");
        reset_bookkeeping();
        repeat (2) @(negedge clk);
        chk("reset_hold_no_write", 32'(valid_opcode), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(mk(6'd1, 5'd8, 5'd9, 5'd10, 11'h0), 1'b0);
        drain();

        for (int k = 0; k < 5; k++)
            issue(mk(legal_ops[k], 5'($urandom), 5'($urandom), 5'($urandom), 11'($urandom)), 1'b0);
        drain();

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                op = legal_ops[$urandom_range(0, 10)];
            end else begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end
            keep = 1'($urandom_range(0, 1));
            if (!held_prev) idle($urandom_range(0, 3));
            issue(mk(op, 5'($urandom), 5'($urandom), 5'($urandom), 11'($urandom)), keep);
        end
        instr_valid = 1'b0;
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
